text_link_ctrl: RTL and testbench

Per-character sequencer for the text link chain. It moves one character at a time from the text source, through the encrypt/Hamming/BPSK transmit path, the channel, and the BPSK/Hamming/decrypt receive path, and finally into the sink. It replaces the free-running stage wiring with explicit start/done handshakes, a per-stage timeout, and error accounting. It sits at the top level, beside the stage instances, and drives their enables.

---
 rtl/text_link_if.sv | 21 ++
 rtl/text_link_ctrl.sv | 109 ++++++++++
 tb/tb_text_link_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/text_link_if.sv
// text_link_if: handshake, strobe and status bundle between text_link_ctrl and the link stages.
interface text_link_if #(parameter int CNT_W = 16);
   logic clr, src_valid, src_last, src_ready, key_ready;
   logic tx_start, tx_done, ch_start, ch_done, rx_start, rx_done;
   logic err_corrected, err_detected, err_fatal;
   logic sink_valid, sink_ready, busy, msg_done, timeout_err;
   logic [CNT_W-1:0] char_count;
   logic [7:0] corr_count, fatal_count;
   modport master (
      input clr, src_valid, src_last, key_ready, tx_done, ch_done, rx_done,
      input err_corrected, err_detected, err_fatal, sink_ready,
      output src_ready, tx_start, ch_start, rx_start, sink_valid, busy, msg_done,
      output timeout_err, char_count, corr_count, fatal_count
   );
   modport slave (
      output clr, src_valid, src_last, key_ready, tx_done, ch_done, rx_done,
      output err_corrected, err_detected, err_fatal, sink_ready,
      input src_ready, tx_start, ch_start, rx_start, sink_valid, busy, msg_done,
      input timeout_err, char_count, corr_count, fatal_count
   );
endinterface

// File: rtl/text_link_ctrl.sv
// text_link_ctrl: per-character sequencer with start/done handshakes, per-stage timeout and error counters.
// Define TEXT_RETRY_EN to retransmit a character through the channel on a fatal Hamming error.
module text_link_ctrl #(
   parameter int TIMEOUT   = 255,
   parameter int MAX_RETRY = 3,
   parameter int CNT_W     = 16
) (
   input logic clk,
   input logic reset,
   text_link_if.master bus
);
   localparam int TW = $clog2(TIMEOUT + 2);
   typedef enum logic [3:0] {IDLE, WAIT_KEY, FETCH, TX, CH, RX, DELIVER, DONE, ERROR} state_t;
   state_t r_state;
   logic [TW-1:0] r_tmo;
   logic r_last, r_tx_start, r_ch_start, r_rx_start, r_timeout_err;
   logic [CNT_W-1:0] r_char_count;
   logic [7:0] r_corr_count, r_fatal_count;
   logic w_tmo_hit, w_retry;
`ifdef TEXT_RETRY_EN
   localparam int RW = $clog2(MAX_RETRY + 2);
   logic [RW-1:0] r_retry;
   assign w_retry = bus.err_fatal && (r_retry < RW'(MAX_RETRY));
   always_ff @(posedge clk or posedge reset)
      if (reset) r_retry <= '0;
      else if (bus.clr || (r_state == FETCH && bus.src_valid)) r_retry <= '0;
      else if (r_state == RX && bus.rx_done && w_retry) r_retry <= r_retry + 1'b1;
`else
   assign w_retry = 1'b0;
`endif
   assign w_tmo_hit = r_tmo == TW'(TIMEOUT);
   // r_tmo defaults to zero every cycle, so it restarts on each state entry and only grows while waiting
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_tmo         <= '0;
         r_last        <= 1'b0;
         r_tx_start    <= 1'b0;
         r_ch_start    <= 1'b0;
         r_rx_start    <= 1'b0;
         r_timeout_err <= 1'b0;
         r_char_count  <= '0;
         r_corr_count  <= '0;
         r_fatal_count <= '0;
      end else begin
         r_tx_start <= 1'b0;
         r_ch_start <= 1'b0;
         r_rx_start <= 1'b0;
         r_tmo      <= '0;
         if (bus.clr) begin
            r_state       <= IDLE;
            r_timeout_err <= 1'b0;
            r_char_count  <= '0;
            r_corr_count  <= '0;
            r_fatal_count <= '0;
         end else begin
            case (r_state)
               IDLE: if (bus.src_valid) r_state <= WAIT_KEY;
               WAIT_KEY: if (bus.key_ready) r_state <= FETCH;
               FETCH: if (bus.src_valid) begin
                  r_last     <= bus.src_last;
                  r_state    <= TX;
                  r_tx_start <= 1'b1;
               end
               TX: if (bus.tx_done) begin
                  r_state    <= CH;
                  r_ch_start <= 1'b1;
               end else if (w_tmo_hit) begin
                  r_state       <= ERROR;
                  r_timeout_err <= 1'b1;
               end else r_tmo <= r_tmo + 1'b1;
               CH: if (bus.ch_done) begin
                  r_state    <= RX;
                  r_rx_start <= 1'b1;
               end else if (w_tmo_hit) begin
                  r_state       <= ERROR;
                  r_timeout_err <= 1'b1;
               end else r_tmo <= r_tmo + 1'b1;
               RX: if (bus.rx_done) begin
                  if (bus.err_fatal) r_fatal_count <= r_fatal_count + {7'd0, r_fatal_count != 8'hFF};
                  else if (bus.err_corrected) r_corr_count <= r_corr_count + {7'd0, r_corr_count != 8'hFF};
                  r_state    <= w_retry ? CH : DELIVER;
                  r_ch_start <= w_retry;
               end else if (w_tmo_hit) begin
                  r_state       <= ERROR;
                  r_timeout_err <= 1'b1;
               end else r_tmo <= r_tmo + 1'b1;
               DELIVER: if (bus.sink_ready) begin
                  r_char_count <= r_char_count + CNT_W'(r_char_count != '1);
                  r_state      <= r_last ? DONE : FETCH;
               end
               DONE: r_state <= IDLE;
               default: r_state <= ERROR;
            endcase
         end
      end
   end
   assign bus.src_ready   = r_state == FETCH;
   assign bus.sink_valid  = r_state == DELIVER;
   assign bus.busy        = r_state != IDLE;
   assign bus.msg_done    = r_state == DONE;
   assign bus.tx_start    = r_tx_start;
   assign bus.ch_start    = r_ch_start;
   assign bus.rx_start    = r_rx_start;
   assign bus.timeout_err = r_timeout_err;
   assign bus.char_count  = r_char_count;
   assign bus.corr_count  = r_corr_count;
   assign bus.fatal_count = r_fatal_count;
endmodule

// File: tb/tb_text_link_ctrl.sv
// tb_text_link_ctrl: directed and randomized sequencing of text_link_ctrl against a per-character model.
module tb_text_link_ctrl;
   localparam int TMO = 8, MR = 3, CW = 16;
`ifdef TEXT_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1;
   int checks = 0, failures = 0;
   int exp_char = 0, exp_corr = 0, exp_fatal = 0;
   text_link_if #(.CNT_W(CW)) bus ();
   text_link_ctrl #(.TIMEOUT(TMO), .MAX_RETRY(MR), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   function automatic logic start_of(int s);
      return s == 0 ? bus.tx_start : s == 1 ? bus.ch_start : bus.rx_start;
   endfunction
   task automatic set_done(int s, logic v);
      if (s == 0) bus.tx_done = v;
      else if (s == 1) bus.ch_done = v;
      else bus.rx_done = v;
   endtask
   task automatic clear_ins();
      bus.tx_done = 0; bus.ch_done = 0; bus.rx_done = 0;
      bus.err_corrected = 0; bus.err_fatal = 0; bus.err_detected = 0;
   endtask
   // Called on the negedge where stage s has just been entered; answers after lat cycles.
   task automatic stage(int s, int lat, bit c, bit f);
      check($sformatf("start_pulse_%0d", s), start_of(s), 1);
      for (int k = 0; k < lat; k++) begin
         if (s == 0) begin
            bus.ch_done = 1'($urandom); bus.rx_done = 1'($urandom);
            bus.err_fatal = 1'($urandom); bus.err_corrected = 1'($urandom);
         end else if (s == 2) begin
            bus.err_fatal = 1'($urandom); bus.err_corrected = 1'($urandom);
         end
         @(negedge clk);
         check($sformatf("start_low_%0d", s), start_of(s), 0);
         check($sformatf("no_sink_%0d", s), bus.sink_valid, 0);
      end
      set_done(s, 1);
      if (s == 2) begin bus.err_corrected = c; bus.err_fatal = f; end
      @(negedge clk);
      clear_ins();
   endtask
   task automatic do_char(bit last, bit c_in, bit f_in, bit rnd);
      int r, g, d;
      bit c, f, again;
      r = 0;
      g = rnd ? int'($urandom_range(0, 2)) : 0;
      bus.src_valid = 0;
      for (int k = 0; k < g; k++) begin
         check("fetch_wait", bus.src_ready, 1);
         @(negedge clk);
      end
      bus.src_valid = 1; bus.src_last = last;
      check("src_ready", bus.src_ready, 1);
      @(negedge clk);
      bus.src_valid = 0; bus.src_last = 0;
      stage(0, rnd ? int'($urandom_range(0, 3)) : 0, 0, 0);
      do begin
         stage(1, rnd ? int'($urandom_range(0, 3)) : 0, 0, 0);
         c = rnd ? 1'($urandom) : c_in;
         f = rnd ? ($urandom_range(0, 3) == 0) : f_in;
         stage(2, rnd ? int'($urandom_range(0, 3)) : 0, c, f);
         if (f) exp_fatal = exp_fatal < 255 ? exp_fatal + 1 : 255;
         else if (c) exp_corr = exp_corr < 255 ? exp_corr + 1 : 255;
         again = RETRY && f && r < MR;
         if (again) r++;
      end while (again);
      check("sink_valid", bus.sink_valid, 1);
      d = rnd ? int'($urandom_range(0, 3)) : 0;
      for (int k = 0; k < d; k++) begin
         @(negedge clk);
         check("sink_hold", bus.sink_valid, 1);
      end
      bus.sink_ready = 1;
      @(negedge clk);
      bus.sink_ready = 0;
      exp_char = exp_char < 65535 ? exp_char + 1 : 65535;
      check("sink_released", bus.sink_valid, 0);
      if (last) begin
         check("msg_done_pulse", bus.msg_done, 1);
         check("busy_in_done", bus.busy, 1);
         @(negedge clk);
         check("msg_done_end", bus.msg_done, 0);
         check("busy_fall", bus.busy, 0);
      end
   endtask
   task automatic start_msg();
      bus.src_valid = 1;
      @(negedge clk);
      check("wait_key_busy", bus.busy, 1);
      for (int k = 0; k < 40 && !bus.src_ready; k++) @(negedge clk);
      check("fetch_reached", bus.src_ready, 1);
   endtask
   task automatic check_counts(string tag);
      check({tag, "_char"}, bus.char_count, exp_char);
      check({tag, "_corr"}, bus.corr_count, exp_corr);
      check({tag, "_fatal"}, bus.fatal_count, exp_fatal);
   endtask
   task automatic run_msg(int n, bit rnd, int cm, int fm);
      start_msg();
      for (int i = 0; i < n; i++) do_char(i == n - 1, cm[i], fm[i], rnd);
      check_counts("msg");
   endtask
   initial begin
      bus.clr = 0; bus.src_valid = 0; bus.src_last = 0; bus.key_ready = 1; bus.sink_ready = 0;
      clear_ins();
      #3;
      check("rst_busy", bus.busy, 0);
      check("rst_src_ready", bus.src_ready, 0);
      check("rst_sink_valid", bus.sink_valid, 0);
      check("rst_starts", {bus.tx_start, bus.ch_start, bus.rx_start, bus.msg_done}, 0);
      check("rst_timeout", bus.timeout_err, 0);
      check_counts("rst");
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      run_msg(3, 0, 0, 0);
      // key schedule not ready: no fetch while waiting
      bus.key_ready = 0; bus.src_valid = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("key_wait_ready", bus.src_ready, 0);
         check("key_wait_busy", bus.busy, 1);
      end
      bus.key_ready = 1;
      @(negedge clk);
      check("key_fetch", bus.src_ready, 1);
      do_char(1, 0, 0, 0);
      check_counts("key");
      run_msg(4, 0, 32'b1101, 32'b0100);
      run_msg(1, 0, 0, 1);
      for (int m = 0; m < 6; m++) run_msg(int'($urandom_range(1, 4)), 1, 0, 0);
      // reset in CH drops the character and clears outputs asynchronously
      start_msg();
      bus.src_last = 0;
      @(negedge clk);
      bus.src_valid = 0;
      stage(0, 0, 0, 0);
      check("ch_entry", bus.ch_start, 1);
      #2 reset = 1;
      #1;
      check("arst_busy", bus.busy, 0);
      check("arst_ch_start", bus.ch_start, 0);
      check("arst_char", bus.char_count, 0);
      check("arst_fatal", bus.fatal_count, 0);
      check("arst_sink", bus.sink_valid, 0);
      @(negedge clk);
      reset = 0;
      exp_char = 0; exp_corr = 0; exp_fatal = 0;
      @(negedge clk);
      run_msg(1, 0, 0, 0);
      // channel never answers: timeout then clr
      start_msg();
      bus.src_last = 1;
      @(negedge clk);
      bus.src_valid = 0; bus.src_last = 0;
      stage(0, 0, 0, 0);
      check("to_ch_start", bus.ch_start, 1);
      for (int k = 1; k <= TMO; k++) begin
         @(negedge clk);
         check("to_pending", bus.timeout_err, 0);
      end
      @(negedge clk);
      check("to_err", bus.timeout_err, 1);
      check("to_busy", bus.busy, 1);
      check("to_no_sink", bus.sink_valid, 0);
      check("to_strobes", {bus.tx_start, bus.ch_start, bus.rx_start, bus.msg_done}, 0);
      bus.ch_done = 1; bus.rx_done = 1; bus.sink_ready = 1; bus.src_valid = 1;
      repeat (3) @(negedge clk);
      clear_ins(); bus.sink_ready = 0; bus.src_valid = 0;
      check("err_sticky", bus.timeout_err, 1);
      check("err_no_sink", bus.sink_valid, 0);
      check("err_no_fetch", bus.src_ready, 0);
      bus.clr = 1;
      @(negedge clk);
      bus.clr = 0;
      exp_char = 0; exp_corr = 0; exp_fatal = 0;
      check("clr_idle", bus.busy, 0);
      check("clr_timeout", bus.timeout_err, 0);
      check_counts("clr");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
